// File: rtl/l2_cache_ctrl_sa.sv
// WAYS-way set-associative write-back / write-allocate L2 controller.
// Victim choice: lowest invalid way, else per-set round-robin; includes whole-cache flush.
module l2_cache_ctrl_sa #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_rw_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LINE_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  output logic [LINE_W-1:0] rsp_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  input  logic              mem_rsp_valid_i,
  input  logic [LINE_W-1:0] mem_rsp_data_i,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  no_acc_o,
  output logic [CNT_W-1:0]  no_hit_o,
  output logic [CNT_W-1:0]  no_miss_o,
  output logic [CNT_W-1:0]  no_wb_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_A = ADDR_W - OFF_W;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT,
    S_RESPOND, S_FLUSH_CHK, S_FLUSH_WB_REQ, S_FLUSH_WB_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  logic              req_rw_q;
  logic [LINE_A-1:0] req_line_q;
  logic [LINE_W-1:0] req_data_q;
  logic [WAY_W-1:0]  vic_way_q;
  logic              vic_rr_q;
  logic [IDX_W-1:0]  fset_q;
  logic [WAY_W-1:0]  fway_q;
  logic [LINE_W-1:0] rsp_data_q;
  logic              busy_q;
  logic              flush_done_q;
  logic [CNT_W-1:0]  acc_q, hit_q, miss_q, wb_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way, inv_way, victim_way;
  logic              inv_found, lookup_hit, victim_dirty;
  logic              f_dirty, f_last;
  logic              accept, do_hit, do_miss, wb_fire, install, f_adv, f_finish;
  logic              unused_addr_bits;

  // Offset bits never matter: the cache only deals in whole lines.
  assign unused_addr_bits = ^req_addr_i[OFF_W-1:0];

  assign req_idx = req_line_q[IDX_W-1:0];
  assign req_tag = req_line_q[LINE_A-1:IDX_W];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
    assign hit_vec[gi] = valid_q[req_idx][gi] && (tag_q[req_idx][gi] == req_tag);
  end

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign lookup_hit   = |hit_vec;
  assign victim_way   = inv_found ? inv_way : rr_q[req_idx];
  assign victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];
  assign f_dirty      = valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q];
  assign f_last       = (&fset_q) && (&fway_q);

  assign req_ready_o  = (state_q == S_IDLE) && !flush_i && !rst_i;
  assign rsp_valid_o  = (state_q == S_RESPOND);
  assign rsp_data_o   = rsp_data_q;
  assign busy_o       = busy_q;
  assign flush_done_o = flush_done_q;
  assign no_acc_o     = acc_q;
  assign no_hit_o     = hit_q;
  assign no_miss_o    = miss_q;
  assign no_wb_o      = wb_q;

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    do_hit          = 1'b0;
    do_miss         = 1'b0;
    wb_fire         = 1'b0;
    install         = 1'b0;
    f_adv           = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end else if (flush_i) begin
          state_d = S_FLUSH_CHK;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          do_hit  = 1'b1;
          state_d = S_RESPOND;
        end else begin
          do_miss = 1'b1;
          state_d = victim_dirty ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {tag_q[req_idx][vic_way_q], req_idx, {OFF_W{1'b0}}};
        mem_req_data_o  = data_q[req_idx][vic_way_q];
        if (mem_req_ready_i) begin
          wb_fire = 1'b1;
          state_d = S_WB_WAIT;
        end
      end
      S_WB_WAIT: if (mem_rsp_valid_i) state_d = S_FILL_REQ;
      S_FILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_req_ready_i) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rsp_valid_i) begin
          install = 1'b1;
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      S_FLUSH_CHK: begin
        if (f_dirty) begin
          state_d = S_FLUSH_WB_REQ;
        end else begin
          f_adv   = 1'b1;
          state_d = f_last ? S_IDLE : S_FLUSH_CHK;
        end
      end
      S_FLUSH_WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {tag_q[fset_q][fway_q], fset_q, {OFF_W{1'b0}}};
        mem_req_data_o  = data_q[fset_q][fway_q];
        if (mem_req_ready_i) begin
          wb_fire = 1'b1;
          state_d = S_FLUSH_WB_WAIT;
        end
      end
      S_FLUSH_WB_WAIT: begin
        if (mem_rsp_valid_i) begin
          f_adv   = 1'b1;
          state_d = f_last ? S_IDLE : S_FLUSH_CHK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign f_finish = f_adv && f_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      req_rw_q     <= 1'b0;
      req_line_q   <= '0;
      req_data_q   <= '0;
      vic_way_q    <= '0;
      vic_rr_q     <= 1'b0;
      fset_q       <= '0;
      fway_q       <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      acc_q        <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      wb_q         <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != S_IDLE);
      flush_done_q <= f_finish;
      if (accept) begin
        req_rw_q   <= req_rw_i;
        req_line_q <= req_addr_i[ADDR_W-1:OFF_W];
        req_data_q <= req_data_i;
        acc_q      <= sat_inc(acc_q);
      end
      if (state_q == S_IDLE && !accept && flush_i) begin
        fset_q <= '0;
        fway_q <= '0;
      end
      if (do_hit) begin
        hit_q      <= sat_inc(hit_q);
        rsp_data_q <= req_rw_q ? req_data_q : data_q[req_idx][hit_way];
        if (req_rw_q) dirty_q[req_idx][hit_way] <= 1'b1;
      end
      if (do_miss) begin
        miss_q    <= sat_inc(miss_q);
        vic_way_q <= victim_way;
        vic_rr_q  <= !inv_found;
      end
      if (wb_fire) wb_q <= sat_inc(wb_q);
      if (install) begin
        valid_q[req_idx][vic_way_q] <= 1'b1;
        dirty_q[req_idx][vic_way_q] <= req_rw_q;
        rsp_data_q <= req_rw_q ? req_data_q : mem_rsp_data_i;
        if (vic_rr_q) rr_q[req_idx] <= rr_q[req_idx] + 1'b1;
      end
      if (f_adv) begin
        valid_q[fset_q][fway_q] <= 1'b0;
        dirty_q[fset_q][fway_q] <= 1'b0;
        fway_q <= fway_q + 1'b1;
        if (&fway_q) fset_q <= fset_q + 1'b1;
      end
      if (f_finish) begin
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end
    end
  end

  // Tag/data payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (do_hit && req_rw_q) data_q[req_idx][hit_way] <= req_data_q;
    if (install) begin
      tag_q[req_idx][vic_way_q]  <= req_tag;
      data_q[req_idx][vic_way_q] <= req_rw_q ? req_data_q : mem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_l2_cache_ctrl_sa.sv
// Directed bench for l2_cache_ctrl_sa: expected responses and memory requests
// are queued by the stimulus and checked by independent monitor processes.
module tb_l2_cache_ctrl_sa;

  logic         clk, rst;
  logic         req_valid, req_rw, flush, mem_req_ready, mem_rsp_valid;
  logic [31:0]  req_addr;
  logic [127:0] req_data, mem_rsp_data;
  logic         req_ready_o, rsp_valid_o, mem_req_valid_o, mem_req_rw_o;
  logic         flush_done_o, busy_o;
  logic [127:0] rsp_data_o, mem_req_data_o;
  logic [31:0]  mem_req_addr_o, no_acc_o, no_hit_o, no_miss_o, no_wb_o;

  l2_cache_ctrl_sa dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready),
    .mem_req_rw_o(mem_req_rw_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i(mem_rsp_data), .flush_i(flush), .flush_done_o(flush_done_o),
    .busy_o(busy_o), .no_acc_o(no_acc_o), .no_hit_o(no_hit_o),
    .no_miss_o(no_miss_o), .no_wb_o(no_wb_o)
  );

  typedef struct packed { logic rw; logic [31:0] addr; logic [127:0] data; } mreq_t;
  typedef struct packed { logic [127:0] data; int lat; } rsp_t;

  mreq_t        exp_mem[$];
  rsp_t         exp_rsp[$];
  logic [127:0] mem_img [logic [31:0]];

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0;
  int n_rsp = 0, n_mem = 0, n_fd = 0;
  int hold_left = 0;
  bit hold_active = 0, stray = 0, drop_rsp = 0;
  logic [31:0] hold_addr_exp = '0;

  localparam logic [127:0] D = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] E = {4{32'hE0E0_1234}};
  localparam logic [127:0] F = {4{32'hF00D_BEEF}};

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {4{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_cnt(input int a, input int h, input int m, input int w);
    chk("no_acc", no_acc_o, 128'(a));
    chk("no_hit", no_hit_o, 128'(h));
    chk("no_miss", no_miss_o, 128'(m));
    chk("no_wb", no_wb_o, 128'(w));
  endtask

  task automatic push_mem(input logic rw, input logic [31:0] a, input logic [127:0] d);
    mreq_t e;
    e.rw = rw; e.addr = a; e.data = d;
    exp_mem.push_back(e);
  endtask

  task automatic wait_rsp(input int target);
    int t = 0;
    while (n_rsp < target && t < 300) begin @(negedge clk); t++; end
    tests++;
    if (n_rsp < target) begin
      fails++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", n_rsp, target);
    end
  endtask

  // Issue one request; optionally queue its expected response and wait for it.
  task automatic do_req(input logic rw, input logic [31:0] a, input logic [127:0] d,
                        input logic [127:0] exp, input int lat, input bit want_rsp);
    int t = 0;
    int target;
    rsp_t e;
    target = n_rsp + 1;
    @(negedge clk);
    req_valid = 1; req_rw = rw; req_addr = a; req_data = d;
    while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
    tests++;
    if (!req_ready_o) begin
      fails++;
      $display("FAIL accept_timeout: addr %0h not accepted", a);
      req_valid = 0;
      return;
    end
    acc_cyc = cyc + 1;
    if (want_rsp) begin
      e.data = exp; e.lat = lat;
      exp_rsp.push_back(e);
    end
    @(negedge clk);
    req_valid = 0;
    if (want_rsp) begin
      wait_rsp(target);
      chk("mem_queue_drained", 128'(exp_mem.size()), 128'd0);
    end
  endtask

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Response monitor: pops the scoreboard on every rsp_valid_o cycle.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (flush_done_o) n_fd++;
      if (!rst && rsp_valid_o) begin
        n_rsp++;
        $display("[TB] rsp data=%0h cyc=%0d", rsp_data_o, cyc);
        if (exp_rsp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got data %0h, expected no response", rsp_data_o);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data_o, e.data);
          if (e.lat >= 0) chk("hit_latency", 128'(cyc + 1 - acc_cyc), 128'(e.lat));
        end
      end
    end
  end

  // Memory model: optional ready stall, checks each handshake against the queue.
  initial begin
    int pend = 0;
    logic [127:0] pend_data = '0;
    mreq_t e;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 0;
      mem_req_ready = 0;
      if (rst) begin pend = 0; hold_active = 0; continue; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin mem_rsp_valid = 1; mem_rsp_data = pend_data; end
      end
      if (hold_left > 0 && (mem_req_valid_o || hold_active)) begin
        hold_active = 1;
        chk("stall_valid", mem_req_valid_o, 1'b1);
        chk("stall_addr", mem_req_addr_o, hold_addr_exp);
        chk("stall_rw", mem_req_rw_o, 1'b0);
        if (stray && hold_left == 3) begin mem_rsp_valid = 1; mem_rsp_data = '1; end
        hold_left--;
        if (hold_left == 0) hold_active = 0;
      end else if (mem_req_valid_o) begin
        mem_req_ready = 1;
        n_mem++;
        $display("[TB] mem rw=%0d addr=%0h data=%0h", mem_req_rw_o, mem_req_addr_o, mem_req_data_o);
        if (exp_mem.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_mem_req: got addr %0h rw %0d, expected none", mem_req_addr_o, mem_req_rw_o);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_rw", mem_req_rw_o, e.rw);
          chk("mem_addr", mem_req_addr_o, e.addr);
          if (e.rw) chk("mem_wdata", mem_req_data_o, e.data);
        end
        if (mem_req_rw_o) begin
          mem_img[mem_req_addr_o] = mem_req_data_o;
          pend_data = '0;
        end else begin
          pend_data = mem_img.exists(mem_req_addr_o) ? mem_img[mem_req_addr_o] : pat(mem_req_addr_o);
        end
        if (!drop_rsp) pend = 2;
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, target, n0;
    rst = 1; req_valid = 0; req_rw = 0; req_addr = '0; req_data = '0; flush = 0;
    mem_img[32'h40] = {16{8'hA5}};
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_mem_valid", mem_req_valid_o, 1'b0);
    chk("rst_flush_done", flush_done_o, 1'b0);
    chk_cnt(0, 0, 0, 0);
    rst = 0;
    #1 chk("idle_req_ready", req_ready_o, 1'b1);

    // Cold miss, then hit on another offset of the same line.
    push_mem(0, 32'h40, '0);
    do_req(0, 32'h40, '0, {16{8'hA5}}, -1, 1);
    chk_cnt(1, 0, 1, 0);
    do_req(0, 32'h44, '0, {16{8'hA5}}, 2, 1);
    chk_cnt(2, 1, 1, 0);

    // Fill all four ways of set 4, then evict the dirty way 0.
    do_req(1, 32'h40, D, D, 2, 1);
    push_mem(0, 32'h140, '0); do_req(0, 32'h140, '0, pat(32'h140), -1, 1);
    push_mem(0, 32'h240, '0); do_req(0, 32'h240, '0, pat(32'h240), -1, 1);
    push_mem(0, 32'h340, '0); do_req(0, 32'h340, '0, pat(32'h340), -1, 1);
    push_mem(1, 32'h40, D);
    push_mem(0, 32'h440, '0); do_req(0, 32'h440, '0, pat(32'h440), -1, 1);
    chk_cnt(7, 2, 5, 1);
    // Round-robin now points at way 1, so 0x140 goes and 0x240/0x340 stay.
    push_mem(0, 32'h540, '0); do_req(0, 32'h540, '0, pat(32'h540), -1, 1);
    do_req(0, 32'h240, '0, pat(32'h240), 2, 1);
    do_req(0, 32'h340, '0, pat(32'h340), 2, 1);
    chk_cnt(10, 4, 6, 1);

    // Exactly two dirty lines, then flush.
    do_req(1, 32'h240, E, E, 2, 1);
    push_mem(0, 32'h80, '0); do_req(1, 32'h80, F, F, -1, 1);
    chk_cnt(12, 5, 7, 1);
    push_mem(1, 32'h240, E);
    push_mem(1, 32'h80, F);
    n0 = n_fd;
    @(negedge clk); flush = 1; req_valid = 1; req_addr = 32'h40; req_rw = 0;
    #1 chk("flush_priority_ready", req_ready_o, 1'b0);
    @(negedge clk); flush = 0; req_valid = 0;
    chk("flush_busy", busy_o, 1'b1);
    t = 0;
    while (n_fd == n0 && t < 1000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("flush_done_pulses", 128'(n_fd - n0), 128'd1);
    chk("flush_busy_after", busy_o, 1'b0);
    chk("flush_mem_drained", 128'(exp_mem.size()), 128'd0);
    chk_cnt(12, 5, 7, 3);
    push_mem(0, 32'h40, '0); do_req(0, 32'h40, '0, D, -1, 1);
    chk_cnt(13, 5, 8, 3);

    // Stalled fill request with a stray completion in the middle.
    hold_left = 5; hold_addr_exp = 32'h1000; stray = 1;
    push_mem(0, 32'h1000, '0); do_req(0, 32'h1000, '0, pat(32'h1000), -1, 1);
    stray = 0;
    chk("stall_consumed", 128'(hold_left), 128'd0);
    chk_cnt(14, 5, 9, 3);

    // Reset while waiting for a fill: nothing comes back, line stays absent.
    drop_rsp = 1;
    target = n_mem + 1;
    push_mem(0, 32'h2000, '0); do_req(0, 32'h2000, '0, '0, -1, 0);
    t = 0;
    while (n_mem < target && t < 50) begin @(negedge clk); t++; end
    chk("abort_fill_issued", 128'(n_mem), 128'(target));
    repeat (3) @(negedge clk);
    chk("wait_busy", busy_o, 1'b1);
    rst = 1;
    #1;
    chk("abort_rsp_valid", rsp_valid_o, 1'b0);
    chk("abort_mem_valid", mem_req_valid_o, 1'b0);
    chk("abort_mem_addr", mem_req_addr_o, 32'h0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_req_ready", req_ready_o, 1'b0);
    chk("abort_rsp_data", rsp_data_o, '0);
    chk_cnt(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 0; drop_rsp = 0;
    repeat (5) @(negedge clk);
    push_mem(0, 32'h2000, '0); do_req(0, 32'h2000, '0, pat(32'h2000), -1, 1);
    chk_cnt(1, 0, 1, 0);

    repeat (5) @(negedge clk);
    chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l2_cache_ctrl_sa.md
Name: l2_cache_ctrl_sa

Overview:
Parametrised successor of the direct-mapped L2 controller: a WAYS-way set-associative, write-back, write-allocate L2 cache with internal tag/data storage.
- Sits between the L1 miss path and the memory controller; both sides use valid/ready handshakes.
- Adds victim selection (first invalid way, else per-set round-robin), unconditional dirty-victim write-back, a full-cache flush mode, and saturating statistics counters.

Parameters:
ADDR_W, 32, request address width
LINE_W, 128, cache line width in bits (power of 2, >=32); OFF_W = log2(LINE_W/8)
SETS, 16, number of sets (power of 2); IDX_W = log2(SETS)
WAYS, 4, associativity (power of 2, >=2)
CNT_W, 32, statistics counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  L1 request valid
req_ready_o  out  1  controller accepts request
req_rw_i  in  1  1 = write (full line), 0 = read
req_addr_i  in  ADDR_W  request address; offset bits ignored
req_data_i  in  LINE_W  write line data
rsp_valid_o  out  1  one-cycle response pulse
rsp_data_o  out  LINE_W  line data (read data, or line as written)
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_rw_o  out  1  1 = write-back, 0 = fill read
mem_req_addr_o  out  ADDR_W  line-aligned address (offset bits = 0)
mem_req_data_o  out  LINE_W  write-back data
mem_rsp_valid_i  in  1  memory completion (read data or write ack)
mem_rsp_data_i  in  LINE_W  fill data
flush_i  in  1  start flush (sampled in IDLE)
flush_done_o  out  1  one-cycle pulse at flush completion
busy_o  out  1  state != IDLE
no_acc_o, no_hit_o, no_miss_o, no_wb_o  out  CNT_W each  access/hit/miss/write-back counters

Behaviour:
- Reset (async, rst_i=1):
  - state IDLE; all valid/dirty bits 0; all rr_ptr 0; counters 0.
  - rsp_valid_o, mem_req_valid_o, flush_done_o, busy_o = 0; req_ready_o = 0 while rst_i=1.
  - Reset mid-transaction abandons it; no response is produced.
- Address split: offset [OFF_W-1:0], index [OFF_W+IDX_W-1:OFF_W], tag = remaining upper bits.
- req_ready_o = (state==IDLE) & ~flush_i & ~rst_i.
- flush_i has priority over req_valid_i in IDLE.
- IDLE:
  - On req_valid_i & req_ready_o: latch rw/addr/data, no_acc++, go to LOOKUP.
  - Else if flush_i: go to FLUSH_CHK with set=0, way=0.
- LOOKUP (one cycle): compare tag against all valid ways of the set.
  - Hit: no_hit++. Read returns the stored line. Write stores req_data and sets dirty=1. Go to RESPOND.
  - Miss: no_miss++. Victim = lowest-index invalid way, else rr_ptr[set].
    - Victim valid & dirty: go to WB_REQ.
    - Otherwise: go to FILL_REQ.
- WB_REQ: mem_req_valid_o=1, rw=1, addr={victim tag, index, 0}, data = victim line, all held stable until mem_req_ready_i. On handshake: no_wb++, go to WB_WAIT.
- WB_WAIT: on mem_rsp_valid_i go to FILL_REQ.
- FILL_REQ: mem_req_valid_o=1, rw=0, addr={req tag, index, 0}, held until mem_req_ready_i; then go to FILL_WAIT.
- FILL_WAIT: on mem_rsp_valid_i:
  - Install victim: tag, valid=1, dirty=rw; line = rw ? req_data : mem_rsp_data_i.
  - If the victim came from rr_ptr, rr_ptr[set] = (rr_ptr+1) mod WAYS.
  - Go to RESPOND.
- RESPOND: rsp_valid_o=1 for exactly one cycle with rsp_data_o = resulting line, then IDLE.
  - Hit latency: rsp_valid_o two cycles after the accept edge.
- FLUSH_CHK (one line per cycle):
  - Line valid & dirty: go to FLUSH_WB (same handshake as WB_REQ/WB_WAIT, no_wb++), then invalidate.
  - Otherwise: invalidate immediately.
  - Advance way, then set.
  - After set SETS-1 / way WAYS-1: clear all rr_ptr, pulse flush_done_o one cycle, go to IDLE.
  - Counters acc/hit/miss are unaffected by flush.
- mem_rsp_valid_i is sampled only in WB_WAIT, FILL_WAIT and the flush wait state; it is ignored elsewhere, including the request-handshake cycle.
- Counters saturate at all-ones and never wrap.
- busy_o is registered from state: 1 in every non-IDLE state.

Test Plan:
- Cold read miss (defaults), read 0x0000_0040 -> mem read addr 0x40 rw=0; mem returns 0xA5..A5 -> rsp_valid_o with 0xA5..A5; no_acc=1, no_miss=1, no_hit=0.
- Read 0x0000_0044 after the above -> hit, no mem request, rsp_valid_o 2 cycles after accept with 0xA5..A5; no_hit=1.
- Write 0x40 data D (hit, dirty); read-miss 0x140, 0x240, 0x340 (ways 1-3); read 0x440 -> mem write addr 0x40 data D (no_wb=1), then fill read 0x440; rr_ptr[4]=1.
- Flush with exactly 2 dirty lines -> exactly 2 mem writes in set/way order, flush_done_o pulses once, busy_o=0 after; a subsequent read of 0x40 misses.
- Hold mem_req_ready_i=0 for 5 cycles in FILL_REQ -> mem_req_valid_o/addr/rw stable all 5 cycles; a stray mem_rsp_valid_i during FILL_REQ is ignored.
- Assert rst_i in FILL_WAIT -> all outputs 0 immediately, no rsp_valid_o; the next read of the same address misses.
